// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - five-channel synchronizer/debouncer with edge pulses
module switch_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic       clk,
   input  logic       rst_btn,
   input  logic [3:0] sw_raw,
   input  logic       btn_raw,
   output logic [3:0] sw_clean,
   output logic [3:0] sw_rise,
   output logic [3:0] sw_fall,
   output logic       sw_changed,
   output logic       step_pulse
);

   localparam int NCH = 5;
   localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {STABLE, PENDING} state_t;

   state_t           state_q [NCH];
   state_t           state_d [NCH];
   logic [CNT_W-1:0] cnt_q   [NCH];
   logic [CNT_W-1:0] cnt_d   [NCH];

   logic [NCH-1:0] sync1;
   logic [NCH-1:0] syncd;
   logic [NCH-1:0] clean_q;
   logic [NCH-1:0] clean_d;
   logic [NCH-1:0] rise_d;
   logic [NCH-1:0] fall_d;
   logic [NCH-1:0] rise_q;
   logic [NCH-1:0] fall_q;
   logic [NCH-1:0] mismatch;
   logic           changed_q;

   assign mismatch = syncd ^ clean_q;

   // Channel 4 is the step button; it only drives step_pulse.
   always_ff @(posedge clk or negedge rst_btn) begin
      if (!rst_btn) begin
         sync1     <= '0;
         syncd     <= '0;
         clean_q   <= '0;
         rise_q    <= '0;
         fall_q    <= '0;
         changed_q <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            state_q[i] <= STABLE;
            cnt_q[i]   <= '0;
         end
      end else begin
         sync1     <= {btn_raw, sw_raw};
         syncd     <= sync1;
         clean_q   <= clean_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         changed_q <= |(rise_d[3:0] | fall_d[3:0]);
         for (int i = 0; i < NCH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
      end
   end

   // A mismatch seen in STABLE already counts as the first cycle of the window,
   // so DEBOUNCE_CYCLES=1 accepts straight from STABLE.
   always_comb begin
      clean_d = clean_q;
      rise_d  = '0;
      fall_d  = '0;
      for (int i = 0; i < NCH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         if (!mismatch[i]) begin
            state_d[i] = STABLE;
            cnt_d[i]   = '0;
         end else if (cnt_q[i] == TERMINAL) begin
            state_d[i] = STABLE;
            cnt_d[i]   = '0;
            clean_d[i] = syncd[i];
            rise_d[i]  = syncd[i];
            fall_d[i]  = ~syncd[i];
         end else begin
            state_d[i] = PENDING;
            cnt_d[i]   = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   assign sw_clean   = clean_q[3:0];
   assign sw_rise    = rise_q[3:0];
   assign sw_fall    = fall_q[3:0];
   assign sw_changed = changed_q;
   assign step_pulse = rise_q[4];

endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - self-checking bench for switch_debouncer (DEBOUNCE_CYCLES=4)
module tb_switch_debouncer;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst_btn = 1'b0;
   logic [3:0] sw_raw = 4'h0;
   logic       btn_raw = 1'b0;
   logic [3:0] sw_clean, sw_rise, sw_fall;
   logic       sw_changed, step_pulse;

   int n_tests = 0;
   int n_fail  = 0;

   switch_debouncer #(.DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
      .clk        (clk),
      .rst_btn    (rst_btn),
      .sw_raw     (sw_raw),
      .btn_raw    (btn_raw),
      .sw_clean   (sw_clean),
      .sw_rise    (sw_rise),
      .sw_fall    (sw_fall),
      .sw_changed (sw_changed),
      .step_pulse (step_pulse)
   );

   always #5 clk = ~clk;

   // Model: raw history delayed two samples, plus a run length of consecutive
   // cycles the delayed level disagrees with the accepted level.
   logic [4:0] hist1, hist2, m_clean, m_rise, m_fall;
   int         m_run [5];

   always @(posedge clk or negedge rst_btn) begin
      if (!rst_btn) begin
         hist1 = '0; hist2 = '0; m_clean = '0; m_rise = '0; m_fall = '0;
         for (int i = 0; i < 5; i++) m_run[i] = 0;
      end else begin
         m_rise = '0;
         m_fall = '0;
         for (int i = 0; i < 5; i++) begin
            if (hist2[i] != m_clean[i]) begin
               m_run[i] = m_run[i] + 1;
               if (m_run[i] == D) begin
                  m_clean[i] = hist2[i];
                  if (hist2[i]) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
                  m_run[i] = 0;
               end
            end else begin
               m_run[i] = 0;
            end
         end
         hist2 = hist1;
         hist1 = {btn_raw, sw_raw};
      end
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      check("model_clean",   {4'h0, sw_clean},  {4'h0, m_clean[3:0]});
      check("model_rise",    {4'h0, sw_rise},   {4'h0, m_rise[3:0]});
      check("model_fall",    {4'h0, sw_fall},   {4'h0, m_fall[3:0]});
      check("model_changed", {7'h0, sw_changed}, {7'h0, |(m_rise[3:0] | m_fall[3:0])});
      check("model_step",    {7'h0, step_pulse}, {7'h0, m_rise[4]});
   end

   int rise2_cnt, bit0_pulses, step_cnt, chg_cnt, pulse_cnt;

   // Advance n cycles, sampling just after each falling edge and counting pulses.
   task automatic cycles(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk); #1;
         rise2_cnt   += int'(sw_rise[2]);
         bit0_pulses += int'(sw_rise[0] | sw_fall[0]);
         step_cnt    += int'(step_pulse);
         chg_cnt     += int'(sw_changed);
         pulse_cnt   += int'(|sw_rise | |sw_fall | sw_changed | step_pulse);
      end
   endtask

   task automatic clear_counts();
      rise2_cnt = 0; bit0_pulses = 0; step_cnt = 0; chg_cnt = 0; pulse_cnt = 0;
   endtask

   initial begin
      int edges;
      clear_counts();
      // Reset held with all switches high.
      sw_raw = 4'hF;
      cycles(4);
      check("rst_clean", {4'h0, sw_clean}, 8'h00);
      check("rst_pulses", 8'(pulse_cnt), 8'd0);
      #1 rst_btn = 1'b1;
      cycles(5);
      check("rel_edge5_clean", {4'h0, sw_clean}, 8'h00);
      cycles(1);
      check("rel_edge6_clean", {4'h0, sw_clean}, 8'h0F);
      check("rel_edge6_rise", {4'h0, sw_rise}, 8'h0F);
      check("rel_edge6_chg", {7'h0, sw_changed}, 8'h01);
      cycles(1);
      check("rel_edge7_rise", {4'h0, sw_rise}, 8'h00);
      check("rel_edge7_chg", {7'h0, sw_changed}, 8'h00);

      // Return to all zero.
      #1 sw_raw = 4'h0;
      cycles(10);
      check("all_low", {4'h0, sw_clean}, 8'h00);

      // Glitch on bit 0: three high cycles then low.
      clear_counts();
      #1 sw_raw[0] = 1'b1;
      cycles(3);
      #1 sw_raw[0] = 1'b0;
      cycles(10);
      check("glitch_clean0", {7'h0, sw_clean[0]}, 8'h00);
      check("glitch_pulses", 8'(bit0_pulses), 8'd0);

      // Bounce on bit 2: 1,0,1 at 2-cycle spacing then hold.
      clear_counts();
      #1 sw_raw[2] = 1'b1;
      cycles(2);
      #1 sw_raw[2] = 1'b0;
      cycles(2);
      #1 sw_raw[2] = 1'b1;
      edges = 0;
      while (sw_clean[2] !== 1'b1 && edges < 20) begin
         cycles(1);
         edges++;
      end
      check("bounce_edges", 8'(edges), 8'd6);
      cycles(8);
      check("bounce_rise2", 8'(rise2_cnt), 8'd1);

      // Button press then release.
      clear_counts();
      #1 btn_raw = 1'b1;
      cycles(10);
      #1 btn_raw = 1'b0;
      cycles(15);
      check("btn_steps", 8'(step_cnt), 8'd1);

      // Simultaneous change 0101 -> 1010.
      #1 sw_raw = 4'b0101;
      cycles(10);
      check("simul_pre", {4'h0, sw_clean}, 8'h05);
      clear_counts();
      #1 sw_raw = 4'b1010;
      cycles(6);
      check("simul_rise", {4'h0, sw_rise}, 8'h0A);
      check("simul_fall", {4'h0, sw_fall}, 8'h05);
      check("simul_chg", {7'h0, sw_changed}, 8'h01);
      cycles(4);
      check("simul_chg_count", 8'(chg_cnt), 8'd1);
      check("simul_clean", {4'h0, sw_clean}, 8'h0A);

      // Mid-count reset on channel 1 (cnt reaches 2 after 4 edges).
      #1 sw_raw = 4'b1000;
      cycles(4);
      #1 rst_btn = 1'b0;
      #1;
      check("midrst_clean", {4'h0, sw_clean}, 8'h00);
      check("midrst_pulse", {3'h0, sw_rise | sw_fall, sw_changed}, 8'h00);
      clear_counts();
      cycles(3);
      #1 rst_btn = 1'b1;
      cycles(5);
      check("midrst_quiet", 8'(pulse_cnt), 8'd0);
      cycles(1);
      check("midrst_rise", {4'h0, sw_rise}, 8'h08);
      check("midrst_fall", {4'h0, sw_fall}, 8'h00);
      cycles(4);
      check("midrst_final", {4'h0, sw_clean}, 8'h08);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of consecutive mismatching cycles needed to accept a new level (legal range 1..2^CNT_W-1).
REQ-002 The block SHALL have parameter CNT_W, default 20, meaning the width of each per-channel stability counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all flops trigger on the rising edge.
REQ-004 The block SHALL have port rst_btn, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port sw_raw, input, 4 bits: raw board switches, asynchronous to clk.
REQ-006 The block SHALL have port btn_raw, input, 1 bit: raw step pushbutton, asynchronous to clk, high when pressed.
REQ-007 The block SHALL have port sw_clean, output, 4 bits: debounced switch levels that feed the register-file/ALU sequencer.
REQ-008 The block SHALL have port sw_rise, output, 4 bits: one-cycle pulse per bit when sw_clean[i] goes 0->1.
REQ-009 The block SHALL have port sw_fall, output, 4 bits: one-cycle pulse per bit when sw_clean[i] goes 1->0.
REQ-010 The block SHALL have port sw_changed, output, 1 bit: one-cycle pulse, the OR of sw_rise and sw_fall.
REQ-011 The block SHALL have port step_pulse, output, 1 bit: one-cycle pulse on an accepted button press.

Function
REQ-012 The block SHALL treat the inputs as 5 identical channels: sw_raw[3:0] are channels 0-3, and btn_raw is channel 4.
REQ-013 Each channel SHALL pass through a 2-flop synchronizer; only the second flop (syncd) is used downstream.
REQ-014 Each channel SHALL hold a debounced state (clean) and a CNT_W-bit counter (cnt).
REQ-015 Each channel SHALL run a 2-state FSM with states STABLE (syncd==clean) and PENDING (syncd!=clean).
REQ-016 In STABLE, cnt SHALL be 0; a mismatch SHALL move the FSM to PENDING, with cnt incrementing from that edge.
REQ-017 In PENDING with a mismatch and cnt==DEBOUNCE_CYCLES-1, the next edge SHALL: set clean<=syncd, set cnt<=0, go to STABLE, and assert that channel's edge pulse for exactly one cycle.
REQ-018 In PENDING, if syncd returns equal to clean before the terminal count, the next edge SHALL set cnt<=0 and go to STABLE; clean SHALL be unchanged and no pulse SHALL be produced (glitch rejected).
REQ-019 Latency: with a raw level held steady, clean SHALL change on rising edge DEBOUNCE_CYCLES+2, counting the first edge that samples the new raw value as edge 1.
REQ-020 A bounce that resets the counter SHALL restart the full DEBOUNCE_CYCLES window; there is no partial credit.
REQ-021 sw_rise[i] and sw_fall[i] SHALL be registered, asserted in the cycle immediately after the edge at which sw_clean[i] changes, and never asserted together.
REQ-022 sw_changed SHALL be high in exactly the cycles where any sw_rise or sw_fall bit is high; simultaneous changes on several bits SHALL produce one shared pulse cycle.
REQ-023 step_pulse SHALL fire only on an accepted 0->1 of channel 4; a button release SHALL produce no output.
REQ-024 The counter SHALL never wrap; the terminal compare SHALL use equality to DEBOUNCE_CYCLES-1.
REQ-025 Channels SHALL be fully independent; activity on one channel SHALL NOT affect another channel's counter.

Reset
REQ-026 rst_btn low SHALL asynchronously clear all synchronizer flops, clean states, counters, and pulse outputs to 0, and force every FSM to STABLE.
REQ-027 While rst_btn is low, sw_clean SHALL be 4'b0000 and all pulse outputs SHALL be 0.
REQ-028 Reset asserted mid-PENDING SHALL discard the partial count; no pulse SHALL be emitted on or after the reset edge.
REQ-029 After rst_btn deasserts, an input already at 1 SHALL be accepted via the normal REQ-019 latency and SHALL produce a rise pulse.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 Reset: hold rst_btn low with sw_raw=4'hF -> sw_clean=0 and no pulses; release -> sw_clean=4'hF at edge 6, sw_rise=4'hF and sw_changed=1 for exactly one cycle.
REQ-031 Glitch: with sw_clean[0]=0, drive sw_raw[0]=1 for 3 cycles, then 0 -> sw_clean[0] stays 0, no pulses.
REQ-032 Bounce: toggle sw_raw[2] 1,0,1 at 2-cycle spacing, then hold 1 -> sw_clean[2] rises exactly 6 edges after the final 0->1, single sw_rise[2].
REQ-033 Button: press btn_raw for 10 cycles, then release -> exactly one step_pulse; no pulse on release.
REQ-034 Simultaneous: sw_raw 4'b0101->4'b1010 in one cycle -> sw_rise=4'b1010 and sw_fall=4'b0101 in the same cycle, one sw_changed pulse.
REQ-035 Mid-count reset: assert rst_btn while cnt=2 on channel 1 -> outputs 0 immediately, no pulse after release until a fresh 6-edge window completes.
